// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger scheduler: FSM state encoding and tag field widths.
package trig_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDead = 2'd2,
    StFull = 2'd3
  } trig_state_e;

  localparam int unsigned BunchW          = 16;
  localparam int unsigned EventW          = 24;
  localparam int unsigned TagW            = BunchW + EventW;
  localparam int unsigned OrbitLenDefault = 3564;

endpackage

// File: rtl/trig_tag_fifo.sv
// Tag buffer: synchronous FIFO with flush and a valid/ready read port. A push into a full
// buffer is refused even when a pop happens in the same cycle.
module trig_tag_fifo
  import trig_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [TagW-1:0] push_data,
  input  logic            ready,
  output logic            valid,
  output logic            full,
  output logic [TagW-1:0] data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [TagW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == (PtrW + 1)'(Depth));
  assign valid   = (cnt_q != '0);
  assign do_push = push && !full;
  assign do_pop  = valid && ready;
  assign data    = valid ? mem_q[rd_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      cnt_q <= cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/trigger_scheduler.sv
// Run-control and T1 trigger sequencer driving the bunch/event counters and queueing tags.
// Optional drop counter enabled by defining TRIG_DROP_COUNT_EN.
module trigger_scheduler
  import trig_pkg::*;
#(
  parameter int unsigned ORBIT_LEN  = OrbitLenDefault,
  parameter int unsigned DEADTIME   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bx_tick,
  input  logic              t1,
  input  logic              run_start,
  input  logic              run_stop,
  input  logic              resync,
  input  logic [BunchW-1:0] bunch_number,
  input  logic [EventW-1:0] event_number,
  output logic              bc_clr,
  output logic              bc_inc,
  output logic              ev_clr,
  output logic              ev_inc,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [BunchW-1:0] tag_bunch,
  output logic [EventW-1:0] tag_event,
  output logic              busy,
  output logic [1:0]        state
`ifdef TRIG_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count,
  input  logic              drop_clr
`endif
);

  localparam logic [BunchW-1:0] LastBunch = BunchW'(ORBIT_LEN - 1);
  localparam logic [7:0]        DeadLoad  = 8'(DEADTIME);

  trig_state_e     state_q;
  logic [7:0]      dead_q;
  logic            active, start, rsync, seq, wrap, accept, fifo_full;
  logic [TagW-1:0] head;

  // run_stop outranks resync, which outranks run_start, which outranks a trigger.
  always_comb begin
    active = (state_q != StIdle);
    start  = !active && run_start && !run_stop;
    rsync  = active && resync && !run_stop;
    seq    = active && bx_tick && !run_stop && !resync;
    wrap   = (bunch_number == LastBunch);
    accept = (state_q == StRun) && bx_tick && t1 && !fifo_full && !run_stop && !resync;
    bc_clr = start || rsync || (seq && wrap);
    bc_inc = seq && !wrap;
    ev_clr = start || rsync;
    ev_inc = accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dead_q  <= '0;
    end else if (run_stop) begin
      state_q <= StIdle;
      dead_q  <= '0;
    end else if (rsync) begin
      state_q <= StRun;
      dead_q  <= '0;
    end else begin
      case (state_q)
        StIdle: if (run_start) state_q <= StRun;
        StRun: begin
          if (accept) begin
            state_q <= StDead;
            dead_q  <= DeadLoad;
          end else if (fifo_full) begin
            state_q <= StFull;
          end
        end
        StDead: begin
          if (bx_tick) begin
            if (dead_q <= 8'd1) begin
              dead_q  <= '0;
              state_q <= fifo_full ? StFull : StRun;
            end else begin
              dead_q <= dead_q - 8'd1;
            end
          end
        end
        StFull: if (!fifo_full) state_q <= StRun;
        default: state_q <= StIdle;
      endcase
    end
  end

  trig_tag_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (rsync),
    .push     (accept),
    .push_data({bunch_number, event_number}),
    .ready    (tag_ready),
    .valid    (tag_valid),
    .full     (fifo_full),
    .data     (head)
  );

  assign tag_bunch = head[TagW-1:EventW];
  assign tag_event = head[EventW-1:0];
  assign busy      = (state_q != StRun) || fifo_full;
  assign state     = state_q;

`ifdef TRIG_DROP_COUNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_clr || run_start || resync) begin
      drop_q <= '0;
    end else if (active && bx_tick && t1 && !accept && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed self-checking bench for trigger_scheduler; models the bunch/event counters from strobes.
module tb_trigger_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, bx_tick, t1, run_start, run_stop, resync, tag_ready;
  logic [15:0] bunch_number;
  logic [23:0] event_number;
  logic        bc_clr, bc_inc, ev_clr, ev_inc, tag_valid, busy;
  logic [15:0] tag_bunch;
  logic [23:0] tag_event;
  logic [1:0]  state;
`ifdef TRIG_DROP_COUNT_EN
  logic [15:0] drop_count;
  logic        drop_clr = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int n_bc_clr, n_bc_inc, n_ev_clr, n_ev_inc;
  logic saw_valid;

  always #5 clk = ~clk;

  trigger_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bx_tick     (bx_tick),
    .t1          (t1),
    .run_start   (run_start),
    .run_stop    (run_stop),
    .resync      (resync),
    .bunch_number(bunch_number),
    .event_number(event_number),
    .bc_clr      (bc_clr),
    .bc_inc      (bc_inc),
    .ev_clr      (ev_clr),
    .ev_inc      (ev_inc),
    .tag_valid   (tag_valid),
    .tag_ready   (tag_ready),
    .tag_bunch   (tag_bunch),
    .tag_event   (tag_event),
    .busy        (busy),
    .state       (state)
`ifdef TRIG_DROP_COUNT_EN
    ,
    .drop_count  (drop_count),
    .drop_clr    (drop_clr)
`endif
  );

  // One clock: sample strobes mid-cycle, then apply them to the counter model after the edge.
  task automatic step();
    logic c, i, ec, ei;
    #1;
    c = bc_clr; i = bc_inc; ec = ev_clr; ei = ev_inc;
    n_bc_clr += int'(c); n_bc_inc += int'(i); n_ev_clr += int'(ec); n_ev_inc += int'(ei);
    if (tag_valid) saw_valid = 1'b1;
    @(posedge clk);
    #1;
    if (c) bunch_number = '0;
    else if (i) bunch_number = bunch_number + 16'd1;
    if (ec) event_number = '0;
    else if (ei) event_number = event_number + 24'd1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bx_tick = 1'b1; step();
      bx_tick = 1'b0; step();
    end
  endtask

  task automatic trig();
    t1 = 1'b1; bx_tick = 1'b1; step();
    t1 = 1'b0; bx_tick = 1'b0; step();
  endtask

  task automatic pop();
    tag_ready = 1'b1; step();
    tag_ready = 1'b0;
  endtask

  task automatic clear_counts();
    n_bc_clr = 0; n_bc_inc = 0; n_ev_clr = 0; n_ev_inc = 0; saw_valid = 1'b0;
  endtask

  task automatic restart_run();
    run_stop = 1'b1; step(); run_stop = 1'b0;
    run_start = 1'b1; step(); run_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (tag_valid !== 1'b0 || tag_bunch !== 16'd0 || tag_event !== 24'd0) begin
      errors++; $display("FAIL reset_tag got=%b/%0d/%0d exp=0/0/0", tag_valid, tag_bunch, tag_event);
    end
    checks++; if ({bc_clr, bc_inc, ev_clr, ev_inc} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {bc_clr, bc_inc, ev_clr, ev_inc});
    end
    rst_n = 1'b1; step();
  endtask

  task automatic test_run_start();
    clear_counts();
    run_start = 1'b1; step(); run_start = 1'b0;
    ticks(10);
    checks++; if (n_bc_clr != 1 || n_ev_clr != 1) begin
      errors++; $display("FAIL start_clr got=%0d/%0d exp=1/1", n_bc_clr, n_ev_clr);
    end
    checks++; if (n_bc_inc != 10) begin errors++; $display("FAIL start_inc got=%0d exp=10", n_bc_inc); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL start_valid got=1 exp=0"); end
    checks++; if (state !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL start_state got=%0d/%b exp=1/0", state, busy);
    end
  endtask

  task automatic test_orbit_wrap();
    bunch_number = 16'd3563;
    bx_tick = 1'b1; t1 = 1'b1; #1;
    checks++; if ({bc_clr, bc_inc, ev_inc} !== 3'b101) begin
      errors++; $display("FAIL wrap_strobes got=%b exp=101", {bc_clr, bc_inc, ev_inc});
    end
    step(); bx_tick = 1'b0; t1 = 1'b0;
    checks++; if (tag_valid !== 1'b1 || tag_bunch !== 16'd3563 || tag_event !== 24'd0) begin
      errors++; $display("FAIL wrap_tag got=%b/%0d/%0d exp=1/3563/0", tag_valid, tag_bunch, tag_event);
    end
    checks++; if (bunch_number !== 16'd0) begin
      errors++; $display("FAIL wrap_counter got=%0d exp=0", bunch_number);
    end
    pop();
    checks++; if (tag_valid !== 1'b0) begin errors++; $display("FAIL wrap_pop got=1 exp=0"); end
    ticks(4);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap_dead_end got=%0d exp=1", state); end
  endtask

  task automatic test_deadtime();
    restart_run(); clear_counts();
    t1 = 1'b1; ticks(6); t1 = 1'b0;
    checks++; if (n_ev_inc != 2) begin errors++; $display("FAIL dead_evinc got=%0d exp=2", n_ev_inc); end
    checks++; if (tag_event !== 24'd0 || tag_bunch !== 16'd0) begin
      errors++; $display("FAIL dead_tag0 got=%0d/%0d exp=0/0", tag_event, tag_bunch);
    end
    pop();
    checks++; if (tag_event !== 24'd1 || tag_bunch !== 16'd5) begin
      errors++; $display("FAIL dead_tag1 got=%0d/%0d exp=1/5", tag_event, tag_bunch);
    end
    pop();
    checks++; if (tag_valid !== 1'b0) begin errors++; $display("FAIL dead_empty got=1 exp=0"); end
    ticks(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dead_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full();
    restart_run(); clear_counts();
    for (int k = 0; k < 4; k++) begin trig(); ticks(4); end
    checks++; if (state !== 2'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL full_state got=%0d/%b exp=3/1", state, busy);
    end
    t1 = 1'b1; bx_tick = 1'b1; #1;
    checks++; if (ev_inc !== 1'b0) begin errors++; $display("FAIL full_drop got=%b exp=0", ev_inc); end
    step(); t1 = 1'b0; bx_tick = 1'b0;
    checks++; if (n_ev_inc != 4) begin errors++; $display("FAIL full_count got=%0d exp=4", n_ev_inc); end
    checks++; if (tag_event !== 24'd0) begin errors++; $display("FAIL full_head got=%0d exp=0", tag_event); end
    pop(); step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL full_leave got=%0d exp=1", state); end
    trig();
    checks++; if (n_ev_inc != 5) begin errors++; $display("FAIL full_accept got=%0d exp=5", n_ev_inc); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (tag_valid !== 1'b1 || tag_event !== 24'(k)) begin
        errors++; $display("FAIL full_drain got=%b/%0d exp=1/%0d", tag_valid, tag_event, k);
      end
      pop();
    end
    ticks(4);
  endtask

  task automatic test_stop_resync();
    restart_run();
    trig(); ticks(4); trig();
    run_stop = 1'b1; resync = 1'b1; bx_tick = 1'b1; #1;
    checks++; if ({bc_clr, bc_inc, ev_clr} !== 3'b000) begin
      errors++; $display("FAIL stop_strobes got=%b exp=000", {bc_clr, bc_inc, ev_clr});
    end
    step(); run_stop = 1'b0; resync = 1'b0; bx_tick = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_state got=%0d exp=0", state); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (tag_valid !== 1'b1 || tag_event !== 24'(k)) begin
        errors++; $display("FAIL stop_drain got=%b/%0d exp=1/%0d", tag_valid, tag_event, k);
      end
      pop();
    end
    checks++; if (tag_valid !== 1'b0) begin errors++; $display("FAIL stop_empty got=1 exp=0"); end
  endtask

  task automatic test_resync_dead();
    run_start = 1'b1; step(); run_start = 1'b0;
    trig(); ticks(4); trig(); ticks(4); trig();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rsync_pre got=%0d exp=2", state); end
    resync = 1'b1; t1 = 1'b1; bx_tick = 1'b1; #1;
    checks++; if ({bc_clr, ev_clr, ev_inc} !== 3'b110) begin
      errors++; $display("FAIL rsync_strobes got=%b exp=110", {bc_clr, ev_clr, ev_inc});
    end
    step(); resync = 1'b0; t1 = 1'b0; bx_tick = 1'b0;
    checks++; if (tag_valid !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL rsync_flush got=%b/%0d exp=0/1", tag_valid, state);
    end
`ifdef TRIG_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd0) begin
      errors++; $display("FAIL rsync_drops got=%0d exp=0", drop_count);
    end
`endif
    trig();
    checks++; if (tag_valid !== 1'b1 || tag_event !== 24'd0) begin
      errors++; $display("FAIL rsync_tag got=%b/%0d exp=1/0", tag_valid, tag_event);
    end
  endtask

  initial begin
    rst_n = 1'b0; bx_tick = 1'b0; t1 = 1'b0; run_start = 1'b0; run_stop = 1'b0;
    resync = 1'b0; tag_ready = 1'b0; bunch_number = '0; event_number = '0;
    clear_counts();
    test_reset();
    test_run_start();
    test_orbit_wrap();
    test_deadtime();
    test_full();
    test_stop_resync();
    test_resync_dead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
